// File: rtl/frame_spreader.sv
`default_nettype none
// ============================================================================
// Module   : frame_spreader
// Function : Spreads one 5-bit code over a 32-sample frame of 4-bit values
//            using a first-order error accumulator. The frame sum encodes
//            the code. Optional `sat` output under FRAME_SPREADER_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module frame_spreader #(
    parameter logic [3:0] IDLE_SAMPLE = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] in_code,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] out_sample,
    output logic       out_valid,
    output logic       frame_start,
    output logic       frame_last
`ifdef FRAME_SPREADER_SAT_EN
    ,
    output logic       sat
`endif
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_RUN     = 1'b1;
    localparam logic [4:0] LAST_IDX   = 5'd31;
    localparam logic [4:0] PRE_IDX    = 5'd30;
    localparam logic [4:0] CLAMP_CODE = 5'd31;
    localparam logic [8:0] CLAMP_SUM  = 9'd480;

    logic [0:0] state_q, state_d;
    logic       pend_q, pend_d;
    logic [4:0] idx_q, idx_d;
    logic [4:0] err_q, err_d;
    logic [3:0] base_q, base_d;
    logic [4:0] rem_q, rem_d;
    logic [3:0] out_sample_q, out_sample_d;
    logic       out_valid_q, out_valid_d;
    logic       frame_start_q, frame_start_d;
    logic       frame_last_q, frame_last_d;
`ifdef FRAME_SPREADER_SAT_EN
    logic       sat_code_q, sat_code_d;
    logic       sat_q, sat_d;
`endif

    logic       accept;
    logic       at_last;
    logic [8:0] code_sum;
    logic [3:0] code_base;
    logic [4:0] code_rem;
    logic [3:0] dp_base;
    logic [4:0] dp_rem;
    logic [4:0] dp_err;
    logic [5:0] e6;
    logic [3:0] dp_sample;

    always_comb begin
        code_sum  = (in_code == CLAMP_CODE) ? CLAMP_SUM : {in_code, 4'b0000};
        code_base = code_sum[8:5];
        code_rem  = code_sum[4:0];
    end

    // pend_q marks the one-cycle gap between an accept from IDLE and sample 0
    assign at_last  = (state_q == ST_RUN) && !pend_q && (idx_q == LAST_IDX);
    assign in_ready = (state_q == ST_IDLE) || at_last;
    assign accept   = in_valid && in_ready;

    // On a back-to-back restart the new code's first sample is computed directly
    always_comb begin
        dp_base   = at_last ? code_base : base_q;
        dp_rem    = at_last ? code_rem  : rem_q;
        dp_err    = at_last ? 5'd0      : err_q;
        e6        = {1'b0, dp_err} + {1'b0, dp_rem};
        dp_sample = dp_base + {3'b000, e6[5]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pend_q        <= 1'b0;
            idx_q         <= 5'd0;
            err_q         <= 5'd0;
            base_q        <= 4'd0;
            rem_q         <= 5'd0;
            out_sample_q  <= IDLE_SAMPLE;
            out_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_last_q  <= 1'b0;
`ifdef FRAME_SPREADER_SAT_EN
            sat_code_q    <= 1'b0;
            sat_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            idx_q         <= idx_d;
            err_q         <= err_d;
            base_q        <= base_d;
            rem_q         <= rem_d;
            out_sample_q  <= out_sample_d;
            out_valid_q   <= out_valid_d;
            frame_start_q <= frame_start_d;
            frame_last_q  <= frame_last_d;
`ifdef FRAME_SPREADER_SAT_EN
            sat_code_q    <= sat_code_d;
            sat_q         <= sat_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        idx_d   = idx_q;
        err_d   = err_q;
        base_d  = base_q;
        rem_d   = rem_q;
`ifdef FRAME_SPREADER_SAT_EN
        sat_code_d = sat_code_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_RUN;
                    pend_d  = 1'b1;
                    idx_d   = 5'd0;
                    err_d   = 5'd0;
                    base_d  = code_base;
                    rem_d   = code_rem;
`ifdef FRAME_SPREADER_SAT_EN
                    sat_code_d = (in_code == CLAMP_CODE);
`endif
                end
            end
            default: begin
                if (pend_q) begin
                    pend_d = 1'b0;
                    err_d  = e6[4:0];
                end else if (idx_q != LAST_IDX) begin
                    idx_d = idx_q + 5'd1;
                    err_d = e6[4:0];
                end else if (accept) begin
                    idx_d  = 5'd0;
                    err_d  = e6[4:0];
                    base_d = code_base;
                    rem_d  = code_rem;
`ifdef FRAME_SPREADER_SAT_EN
                    sat_code_d = (in_code == CLAMP_CODE);
`endif
                end else begin
                    state_d = ST_IDLE;
                    idx_d   = 5'd0;
                    err_d   = 5'd0;
                end
            end
        endcase
    end

    always_comb begin
        out_sample_d  = IDLE_SAMPLE;
        out_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        frame_last_d  = 1'b0;
`ifdef FRAME_SPREADER_SAT_EN
        sat_d         = 1'b0;
`endif
        if ((state_q == ST_RUN) && (pend_q || (idx_q != LAST_IDX) || accept)) begin
            out_sample_d  = dp_sample;
            out_valid_d   = 1'b1;
            frame_start_d = pend_q || at_last;
            frame_last_d  = !pend_q && (idx_q == PRE_IDX);
`ifdef FRAME_SPREADER_SAT_EN
            sat_d         = at_last ? (in_code == CLAMP_CODE) : sat_code_q;
`endif
        end
    end

    assign out_sample  = out_sample_q;
    assign out_valid   = out_valid_q;
    assign frame_start = frame_start_q;
    assign frame_last  = frame_last_q;
`ifdef FRAME_SPREADER_SAT_EN
    assign sat         = sat_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_frame_spreader.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_spreader
// Function : Scoreboard bench for frame_spreader; expected frames are built
//            from the cumulative-sum form floor(n*S/32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_spreader;

    localparam logic [3:0] TB_IDLE = 4'd5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] in_code = 5'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] out_sample;
    logic       out_valid;
    logic       frame_start;
    logic       frame_last;
`ifdef FRAME_SPREADER_SAT_EN
    logic       sat;
`endif

    frame_spreader #(.IDLE_SAMPLE(TB_IDLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_code    (in_code),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_sample (out_sample),
        .out_valid  (out_valid),
        .frame_start(frame_start),
        .frame_last (frame_last)
`ifdef FRAME_SPREADER_SAT_EN
        ,
        .sat        (sat)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] smp;
        logic       st;
        logic       ls;
        logic       sat;
        logic [8:0] sum;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    int         samp_cnt = 0;
    logic [8:0] acc = 9'd0;
    logic       mon_en = 1'b0;
    exp_t       mon_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [4:0] code);
        int   s_tot;
        exp_t e;
        s_tot = (code == 5'd31) ? 480 : int'(code) * 16;
        for (int i = 0; i < 32; i++) begin
            e.smp = 4'((s_tot * (i + 1)) / 32 - (s_tot * i) / 32);
            e.st  = (i == 0);
            e.ls  = (i == 31);
            e.sat = (code == 5'd31);
            e.sum = 9'(s_tot);
            sb.push_back(e);
        end
    endtask

    // Presents a code and returns at the falling edge after it is accepted
    task automatic send(input logic [4:0] code);
        int n;
        in_code  = code;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        else push_frame(code);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && mon_en) begin
            if (out_valid) begin
                check("in_ready_in_frame", in_ready, frame_last);
                check("marker_overlap", frame_start & frame_last, 0);
                acc      = frame_start ? 9'(out_sample) : acc + 9'(out_sample);
                samp_cnt = frame_start ? 1 : samp_cnt + 1;
                if (sb.size() == 0) begin
                    check("unexpected_sample", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("sample", out_sample, mon_e.smp);
                    check("frame_start", frame_start, mon_e.st);
                    check("frame_last", frame_last, mon_e.ls);
`ifdef FRAME_SPREADER_SAT_EN
                    check("sat", sat, mon_e.sat);
`endif
                    if (mon_e.ls) check("frame_sum", acc, mon_e.sum);
                end
            end else begin
                check("idle_sample", out_sample, TB_IDLE);
                check("idle_markers", {frame_start, frame_last}, 0);
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_sample", out_sample, TB_IDLE);
        check("rst_start", frame_start, 0);
        check("rst_last", frame_last, 0);
`ifdef FRAME_SPREADER_SAT_EN
        check("rst_sat", sat, 0);
`endif
        rst = 1'b0;
        #1;
        check("rst_ready", in_ready, 1);
        mon_en = 1'b1;

        send(5'd0);
        drain();
        send(5'd7);
        drain();
        send(5'd31);
        drain();

        // back-to-back: second code waits for the frame_last cycle
        send(5'd10);
        send(5'd1);
        drain();

        // asynchronous reset in the middle of a frame
        send(5'd20);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(out_valid && samp_cnt == 12) && n < 100);
        if (!(out_valid && samp_cnt == 12)) check("mid_frame_timeout", 0, 1);
        #2 rst = 1'b1;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_sample", out_sample, TB_IDLE);
        check("abort_start", frame_start, 0);
        check("abort_last", frame_last, 0);
`ifdef FRAME_SPREADER_SAT_EN
        check("abort_sat", sat, 0);
`endif
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_ready", in_ready, 1);
        send(5'd2);
        drain();

        // held valid with changing code: only the frame_last-cycle value counts
        send(5'd5);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            in_code = 5'($urandom_range(0, 31));
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("hold_timeout", 0, 1);
        in_code = 5'd9;
        push_frame(5'd9);
        @(negedge clk);
        in_valid = 1'b0;
        drain();

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
